// File: rtl/mem_uart_tx_dump_if.sv
// Host, data-memory read port and UART line of the memory dump engine.
// The engine side uses the master modport; the host/memory side uses slave.
interface mem_uart_tx_dump_if;
  logic        start;
  logic [3:0]  first_addr;
  logic [4:0]  word_count;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (
    input  start, first_addr, word_count, mem_rd_data,
    output mem_rd_en, mem_rd_addr, tx, busy, done
  );

  modport slave (
    output start, first_addr, word_count, mem_rd_data,
    input  mem_rd_en, mem_rd_addr, tx, busy, done
  );
endinterface

// File: rtl/mem_uart_tx_dump.sv
// Streams a block of 16-bit data-memory words out of an 8N1 UART TX line.
// Each word goes out as two bytes, high byte first, with bits LSB first.
module mem_uart_tx_dump #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic               clk,
  input  logic               reset,
  mem_uart_tx_dump_if.master bus
);

  localparam int              CntW    = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP, NEXT} stateT;

  stateT           state;
  stateT           stateNext;
  logic [CntW-1:0] baudCnt;
  logic [2:0]      bitIdx;
  logic            hiSel;
  logic [15:0]     wordReg;
  logic [3:0]      addr;
  logic [4:0]      remaining;
  logic            txReg;
  logic            busyReg;
  logic            doneReg;
  logic            rdEn;
  logic            txNext;

  logic            bitEnd;
  logic            accept;
  logic            emptyReq;
  logic            lastWord;
  logic [7:0]      curByte;

  assign bitEnd   = (baudCnt == LastCnt);
  assign accept   = (state == IDLE) && bus.start && (bus.word_count != 5'd0);
  assign emptyReq = (state == IDLE) && bus.start && (bus.word_count == 5'd0);
  assign lastWord = (remaining == 5'd1);
  assign curByte  = hiSel ? wordReg[15:8] : wordReg[7:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = FETCH;
      FETCH:   stateNext = LOAD;
      LOAD:    stateNext = START;
      START:   if (bitEnd) stateNext = DATA;
      DATA:    if (bitEnd && bitIdx == 3'd7) stateNext = STOP;
      STOP:    if (bitEnd) stateNext = hiSel ? START : NEXT;
      NEXT:    stateNext = lastWord ? IDLE : FETCH;
      default: stateNext = IDLE;
    endcase
  end

  // tx is computed from the current state and registered, so the line trails
  // the state machine by one cycle and never glitches.
  always_comb begin
    rdEn   = (state == FETCH);
    txNext = 1'b1;
    case (state)
      START:   txNext = 1'b0;
      DATA:    txNext = curByte[bitIdx];
      default: txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baudCnt   <= '0;
      bitIdx    <= '0;
      hiSel     <= 1'b1;
      wordReg   <= '0;
      addr      <= '0;
      remaining <= '0;
      txReg     <= 1'b1;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
    end else begin
      txReg   <= txNext;
      doneReg <= emptyReq || (state == NEXT && lastWord);

      if (state == START || state == DATA || state == STOP)
        baudCnt <= bitEnd ? '0 : baudCnt + CntW'(1);
      else
        baudCnt <= '0;

      if (state != DATA)  bitIdx <= '0;
      else if (bitEnd)    bitIdx <= bitIdx + 3'd1;

      // The high byte always goes first; the first stop bit flips to the low byte.
      if (state == LOAD) begin
        wordReg <= bus.mem_rd_data;
        hiSel   <= 1'b1;
      end else if (state == STOP && bitEnd) begin
        hiSel   <= 1'b0;
      end

      if (accept) begin
        addr      <= bus.first_addr;
        remaining <= bus.word_count;
        busyReg   <= 1'b1;
      end else if (state == NEXT) begin
        remaining <= remaining - 5'd1;
        if (lastWord) busyReg <= 1'b0;
        else          addr    <= addr + 4'd1;
      end
    end
  end

  assign bus.mem_rd_en   = rdEn;
  assign bus.mem_rd_addr = addr;
  assign bus.tx          = txReg;
  assign bus.busy        = busyReg;
  assign bus.done        = doneReg;

endmodule

// File: tb/tb_mem_uart_tx_dump.sv
// Directed bench for mem_uart_tx_dump at 4 clocks per bit, with a 1-cycle
// latency behavioural data memory and a cycle-accurate UART line decoder.
module tb_mem_uart_tx_dump;
  localparam int Cpb    = 4;
  localparam int FrameC = 10 * Cpb;
  localparam int WordC  = 2 * FrameC + 3;
  localparam int LogMax = 2048;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_uart_tx_dump_if bus();

  mem_uart_tx_dump #(.CLKS_PER_BIT(Cpb)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [0:15];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

  int checks = 0;
  int fails  = 0;

  logic       txLog [0:LogMax-1];
  logic [3:0] rdAddrs [0:31];
  logic [7:0] frameByte [0:63];
  int         frameStart [0:63];
  int logLen, busyCycles, doneCycles, doneIdx, txLowCount, rdCount, timedOut;
  int nFrames, gridErr;

  // Splits the logged tx line into 8N1 frames, counting samples off the bit grid.
  task automatic decode_log();
    int i;
    logic [7:0] b;
    nFrames = 0; gridErr = 0; i = 0; b = '0;
    while (i < logLen) begin
      if (txLog[i] !== 1'b0) i++;
      else if (i + FrameC > logLen) begin gridErr++; i = logLen; end
      else begin
        for (int k = 0; k < Cpb; k++) if (txLog[i+k] !== 1'b0) gridErr++;
        for (int d = 0; d < 8; d++) begin
          b[d] = txLog[i+Cpb+Cpb*d];
          for (int k = 1; k < Cpb; k++) if (txLog[i+Cpb+Cpb*d+k] !== b[d]) gridErr++;
        end
        for (int k = 9*Cpb; k < FrameC; k++) if (txLog[i+k] !== 1'b1) gridErr++;
        if (nFrames < 64) begin frameByte[nFrames] = b; frameStart[nFrames] = i; end
        nFrames++;
        i += FrameC;
      end
    end
  endtask

  // Pulses start at the next edge and logs one sample per cycle (index k is the
  // cycle after edge k) until `tail` cycles after done, or maxCyc runs out.
  // start is re-pulsed with other arguments at indices repA and repB.
  task automatic do_block(input logic [3:0] fa, input logic [4:0] wc, input int maxCyc,
                          input int tail, input int repA, input int repB);
    int stopAt;
    stopAt = -1;
    logLen = 0; busyCycles = 0; doneCycles = 0; doneIdx = -1;
    txLowCount = 0; rdCount = 0; timedOut = 1;
    bus.start = 1'b1; bus.first_addr = fa; bus.word_count = wc;
    for (int i = 0; i < maxCyc && i < LogMax; i++) begin
      @(negedge clk);
      bus.start = (i == repA || i == repB);
      if (i == repA || i == repB) begin bus.first_addr = 4'd0; bus.word_count = 5'd5; end
      txLog[logLen] = bus.tx; logLen++;
      if (bus.tx === 1'b0) txLowCount++;
      if (bus.busy === 1'b1) busyCycles++;
      if (bus.done === 1'b1) begin
        doneCycles++;
        if (doneIdx < 0) begin doneIdx = i; stopAt = i + tail; end
      end
      if (bus.mem_rd_en === 1'b1) begin
        if (rdCount < 32) rdAddrs[rdCount] = bus.mem_rd_addr;
        rdCount++;
      end
      if (i == stopAt) begin timedOut = 0; break; end
    end
    decode_log();
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.start = 1'b0; bus.first_addr = '0; bus.word_count = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.tx !== 1'b1) begin fails++; $display("FAIL reset tx: got %b want 1", bus.tx); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset done: got %b want 0", bus.done); end
    checks++; if (bus.mem_rd_en !== 1'b0) begin fails++; $display("FAIL reset mem_rd_en: got %b want 0", bus.mem_rd_en); end
    checks++; if (bus.mem_rd_addr !== 4'd0) begin fails++; $display("FAIL reset mem_rd_addr: got %0d want 0", bus.mem_rd_addr); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    mem[3] = 16'hA55A;
    do_block(4'd3, 5'd1, 200, 2, -1, -1);
    checks++; if (timedOut !== 0) begin fails++; $display("FAIL single timeout: got %0d want 0", timedOut); end
    checks++; if (nFrames !== 2) begin fails++; $display("FAIL single frames: got %0d want 2", nFrames); end
    checks++; if (frameByte[0] !== 8'hA5) begin fails++; $display("FAIL single byte0: got %h want a5", frameByte[0]); end
    checks++; if (frameByte[1] !== 8'h5A) begin fails++; $display("FAIL single byte1: got %h want 5a", frameByte[1]); end
    checks++; if (frameStart[0] !== 3) begin fails++; $display("FAIL single first_low: got %0d want 3", frameStart[0]); end
    checks++; if (frameStart[1] !== 43) begin fails++; $display("FAIL single second_start: got %0d want 43", frameStart[1]); end
    checks++; if (gridErr !== 0) begin fails++; $display("FAIL single grid: got %0d errors want 0", gridErr); end
    checks++; if (busyCycles !== 83) begin fails++; $display("FAIL single busy_width: got %0d want 83", busyCycles); end
    checks++; if (doneCycles !== 1) begin fails++; $display("FAIL single done_cycles: got %0d want 1", doneCycles); end
    checks++; if (doneIdx !== 83) begin fails++; $display("FAIL single done_idx: got %0d want 83", doneIdx); end
    checks++; if (rdCount !== 1) begin fails++; $display("FAIL single reads: got %0d want 1", rdCount); end
    checks++; if (rdAddrs[0] !== 4'd3) begin fails++; $display("FAIL single rd_addr: got %0d want 3", rdAddrs[0]); end
  endtask

  task automatic test_wrap();
    logic [3:0] expAddr;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
    do_block(4'd14, 5'd16, 1500, 2, -1, -1);
    checks++; if (timedOut !== 0) begin fails++; $display("FAIL wrap timeout: got %0d want 0", timedOut); end
    checks++; if (rdCount !== 16) begin fails++; $display("FAIL wrap reads: got %0d want 16", rdCount); end
    checks++; if (nFrames !== 32) begin fails++; $display("FAIL wrap frames: got %0d want 32", nFrames); end
    checks++; if (gridErr !== 0) begin fails++; $display("FAIL wrap grid: got %0d errors want 0", gridErr); end
    checks++; if (doneCycles !== 1) begin fails++; $display("FAIL wrap done_cycles: got %0d want 1", doneCycles); end
    checks++; if (busyCycles !== 16*WordC) begin fails++; $display("FAIL wrap busy_width: got %0d want %0d", busyCycles, 16*WordC); end
    checks++; if (doneIdx !== 16*WordC) begin fails++; $display("FAIL wrap done_idx: got %0d want %0d", doneIdx, 16*WordC); end
    for (int w = 0; w < 16; w++) begin
      expAddr = 4'(14 + w);
      checks++; if (rdAddrs[w] !== expAddr) begin fails++; $display("FAIL wrap rd_addr[%0d]: got %0d want %0d", w, rdAddrs[w], expAddr); end
      checks++; if (frameByte[2*w] !== 8'h01) begin fails++; $display("FAIL wrap hi_byte[%0d]: got %h want 01", w, frameByte[2*w]); end
      checks++; if (frameByte[2*w+1] !== {4'h0, expAddr}) begin fails++; $display("FAIL wrap lo_byte[%0d]: got %h want %h", w, frameByte[2*w+1], {4'h0, expAddr}); end
      checks++; if (frameStart[2*w] !== 3 + WordC*w) begin fails++; $display("FAIL wrap hi_start[%0d]: got %0d want %0d", w, frameStart[2*w], 3 + WordC*w); end
      checks++; if (frameStart[2*w+1] !== 43 + WordC*w) begin fails++; $display("FAIL wrap lo_start[%0d]: got %0d want %0d", w, frameStart[2*w+1], 43 + WordC*w); end
    end
  endtask

  task automatic test_zero_count();
    do_block(4'd5, 5'd0, 10, 3, -1, -1);
    checks++; if (timedOut !== 0) begin fails++; $display("FAIL zero timeout: got %0d want 0", timedOut); end
    checks++; if (doneIdx !== 0) begin fails++; $display("FAIL zero done_idx: got %0d want 0", doneIdx); end
    checks++; if (doneCycles !== 1) begin fails++; $display("FAIL zero done_cycles: got %0d want 1", doneCycles); end
    checks++; if (busyCycles !== 0) begin fails++; $display("FAIL zero busy: got %0d cycles want 0", busyCycles); end
    checks++; if (txLowCount !== 0) begin fails++; $display("FAIL zero tx_low: got %0d cycles want 0", txLowCount); end
    checks++; if (rdCount !== 0) begin fails++; $display("FAIL zero reads: got %0d want 0", rdCount); end
  endtask

  task automatic test_ignore_start();
    mem[7] = 16'h1234; mem[8] = 16'hBEEF;
    do_block(4'd7, 5'd2, 400, 2, 50, 82);
    checks++; if (timedOut !== 0) begin fails++; $display("FAIL ignore timeout: got %0d want 0", timedOut); end
    checks++; if (nFrames !== 4) begin fails++; $display("FAIL ignore frames: got %0d want 4", nFrames); end
    checks++; if (frameByte[0] !== 8'h12) begin fails++; $display("FAIL ignore byte0: got %h want 12", frameByte[0]); end
    checks++; if (frameByte[1] !== 8'h34) begin fails++; $display("FAIL ignore byte1: got %h want 34", frameByte[1]); end
    checks++; if (frameByte[2] !== 8'hBE) begin fails++; $display("FAIL ignore byte2: got %h want be", frameByte[2]); end
    checks++; if (frameByte[3] !== 8'hEF) begin fails++; $display("FAIL ignore byte3: got %h want ef", frameByte[3]); end
    checks++; if (gridErr !== 0) begin fails++; $display("FAIL ignore grid: got %0d errors want 0", gridErr); end
    checks++; if (rdCount !== 2) begin fails++; $display("FAIL ignore reads: got %0d want 2", rdCount); end
    checks++; if (rdAddrs[0] !== 4'd7) begin fails++; $display("FAIL ignore rd_addr0: got %0d want 7", rdAddrs[0]); end
    checks++; if (rdAddrs[1] !== 4'd8) begin fails++; $display("FAIL ignore rd_addr1: got %0d want 8", rdAddrs[1]); end
    checks++; if (busyCycles !== 2*WordC) begin fails++; $display("FAIL ignore busy_width: got %0d want %0d", busyCycles, 2*WordC); end
    checks++; if (doneCycles !== 1) begin fails++; $display("FAIL ignore done_cycles: got %0d want 1", doneCycles); end
  endtask

  task automatic test_reset_mid();
    mem[9] = 16'h5A5A; mem[10] = 16'h0000; mem[11] = 16'hFFFF;
    bus.start = 1'b1; bus.first_addr = 4'd9; bus.word_count = 5'd3;
    for (int i = 0; i <= 100; i++) begin @(negedge clk); bus.start = 1'b0; end
    // Cycle 100 lies in bit 2 of word 2's high byte, which is 0.
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL midrst pre_busy: got %b want 1", bus.busy); end
    checks++; if (bus.tx !== 1'b0) begin fails++; $display("FAIL midrst pre_tx: got %b want 0", bus.tx); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.tx !== 1'b1) begin fails++; $display("FAIL midrst tx: got %b want 1", bus.tx); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst busy: got %b want 0", bus.busy); end
    checks++; if (bus.mem_rd_en !== 1'b0) begin fails++; $display("FAIL midrst mem_rd_en: got %b want 0", bus.mem_rd_en); end
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL midrst done: got %b want 0", bus.done); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem[9] = 16'h3CC3;
    do_block(4'd9, 5'd1, 200, 2, -1, -1);
    checks++; if (timedOut !== 0) begin fails++; $display("FAIL midrst timeout: got %0d want 0", timedOut); end
    checks++; if (nFrames !== 2) begin fails++; $display("FAIL midrst frames: got %0d want 2", nFrames); end
    checks++; if (frameByte[0] !== 8'h3C) begin fails++; $display("FAIL midrst byte0: got %h want 3c", frameByte[0]); end
    checks++; if (frameByte[1] !== 8'hC3) begin fails++; $display("FAIL midrst byte1: got %h want c3", frameByte[1]); end
    checks++; if (frameStart[0] !== 3) begin fails++; $display("FAIL midrst first_low: got %0d want 3", frameStart[0]); end
    checks++; if (gridErr !== 0) begin fails++; $display("FAIL midrst grid: got %0d errors want 0", gridErr); end
    checks++; if (busyCycles !== 83) begin fails++; $display("FAIL midrst busy_width: got %0d want 83", busyCycles); end
    checks++; if (rdAddrs[0] !== 4'd9) begin fails++; $display("FAIL midrst rd_addr: got %0d want 9", rdAddrs[0]); end
  endtask

  task automatic test_back_to_back();
    mem[0] = 16'hC381; mem[1] = 16'h7E24;
    do_block(4'd0, 5'd1, 200, 1, -1, -1);
    checks++; if (doneIdx !== 83) begin fails++; $display("FAIL b2b first_done: got %0d want 83", doneIdx); end
    checks++; if (nFrames !== 2) begin fails++; $display("FAIL b2b first_frames: got %0d want 2", nFrames); end
    checks++; if (frameByte[0] !== 8'hC3) begin fails++; $display("FAIL b2b first_byte0: got %h want c3", frameByte[0]); end
    checks++; if (frameByte[1] !== 8'h81) begin fails++; $display("FAIL b2b first_byte1: got %h want 81", frameByte[1]); end
    do_block(4'd1, 5'd1, 200, 2, -1, -1);
    checks++; if (timedOut !== 0) begin fails++; $display("FAIL b2b timeout: got %0d want 0", timedOut); end
    checks++; if (nFrames !== 2) begin fails++; $display("FAIL b2b frames: got %0d want 2", nFrames); end
    checks++; if (frameByte[0] !== 8'h7E) begin fails++; $display("FAIL b2b byte0: got %h want 7e", frameByte[0]); end
    checks++; if (frameByte[1] !== 8'h24) begin fails++; $display("FAIL b2b byte1: got %h want 24", frameByte[1]); end
    checks++; if (frameStart[0] !== 3) begin fails++; $display("FAIL b2b first_low: got %0d want 3", frameStart[0]); end
    checks++; if (frameStart[1] !== 43) begin fails++; $display("FAIL b2b second_start: got %0d want 43", frameStart[1]); end
    checks++; if (gridErr !== 0) begin fails++; $display("FAIL b2b grid: got %0d errors want 0", gridErr); end
    checks++; if (busyCycles !== 83) begin fails++; $display("FAIL b2b busy_width: got %0d want 83", busyCycles); end
    checks++; if (doneIdx !== 83) begin fails++; $display("FAIL b2b done_idx: got %0d want 83", doneIdx); end
    checks++; if (rdAddrs[0] !== 4'd1) begin fails++; $display("FAIL b2b rd_addr: got %0d want 1", rdAddrs[0]); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_wrap();
    test_zero_count();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
